// File: rtl/demo2_pump_sequencer_if.sv
// Pump sequencer control/status bundle.
// master drives start/abort; slave is the sequencer.
interface demo2_pump_sequencer_if;
    logic       start;
    logic       abort;
    logic [2:0] pump_en;
    logic       valve_out;
    logic       flush_en;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] run_count;
    logic [2:0] state;

    modport master (
        output start,
        output abort,
        input  pump_en,
        input  valve_out,
        input  flush_en,
        input  busy,
        input  done,
        input  aborted,
        input  run_count,
        input  state
    );

    modport slave (
        input  start,
        input  abort,
        output pump_en,
        output valve_out,
        output flush_en,
        output busy,
        output done,
        output aborted,
        output run_count,
        output state
    );
endinterface

// File: rtl/demo2_pump_sequencer.sv
// Three-solution pump sequencer: prime, mix, dispense, flush.
// All outputs are registered from the state being entered.
module demo2_pump_sequencer #(
    parameter int CNT_W    = 8,
    parameter int T_PRIME3 = 40,
    parameter int T_PRIME2 = 20,
    parameter int T_MIX    = 30,
    parameter int T_DISP   = 50,
    parameter int T_FLUSH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demo2_pump_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRIME3   = 3'd1,
        S_PRIME2   = 3'd2,
        S_MIX      = 3'd3,
        S_DISPENSE = 3'd4,
        S_FLUSH    = 3'd5
    } state_t;

    localparam int MAX_T = (1 << CNT_W) - 1;

    if (T_PRIME3 > MAX_T || T_PRIME2 > MAX_T || T_MIX > MAX_T ||
        T_DISP > MAX_T || T_FLUSH > MAX_T) begin : g_cfg_err
        $error("phase duration does not fit in CNT_W bits");
    end

    // A zero duration still occupies one cycle.
    function automatic logic [CNT_W-1:0] dur(input int t);
        return (t < 1) ? CNT_W'(1) : CNT_W'(t);
    endfunction

    state_t           st_q;
    state_t           st_d;
    state_t           nxt_ph;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] nxt_len;
    logic             ab_q;
    logic             ab_d;
    logic             fin;
    logic             last;
    logic [2:0]       pump_d;

    logic [2:0]       pump_q;
    logic             valve_q;
    logic             flush_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic [7:0]       rc_q;

    assign last = (cnt_q <= CNT_W'(1));

    // Successor phase and its duration for the normal chain.
    always_comb begin
        nxt_ph  = S_IDLE;
        nxt_len = '0;
        unique case (st_q)
            S_PRIME3: begin
                nxt_ph  = S_PRIME2;
                nxt_len = dur(T_PRIME2);
            end
            S_PRIME2: begin
                nxt_ph  = S_MIX;
                nxt_len = dur(T_MIX);
            end
            S_MIX: begin
                nxt_ph  = S_DISPENSE;
                nxt_len = dur(T_DISP);
            end
            S_DISPENSE: begin
                nxt_ph  = S_FLUSH;
                nxt_len = dur(T_FLUSH);
            end
            default: begin
                nxt_ph  = S_IDLE;
                nxt_len = '0;
            end
        endcase
    end

    // Next state, phase counter and abort flag.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        ab_d  = ab_q;
        fin   = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                ab_d = 1'b0;
                if (bus.start && !bus.abort) begin
                    st_d  = S_PRIME3;
                    cnt_d = dur(T_PRIME3);
                end
            end
            S_PRIME3, S_PRIME2, S_MIX, S_DISPENSE: begin
                if (bus.abort) begin
                    st_d  = S_FLUSH;
                    cnt_d = dur(T_FLUSH);
                    ab_d  = 1'b1;
                end else if (last) begin
                    st_d  = nxt_ph;
                    cnt_d = nxt_len;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (last) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                    ab_d  = 1'b0;
                    fin   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                st_d  = S_IDLE;
                cnt_d = '0;
                ab_d  = 1'b0;
            end
        endcase
    end

    // Pump enables for the state being entered.
    always_comb begin
        pump_d = 3'b000;
        unique case (st_d)
            S_PRIME3:   pump_d = 3'b100;
            S_PRIME2:   pump_d = 3'b110;
            S_MIX:      pump_d = 3'b111;
            S_DISPENSE: pump_d = 3'b111;
            default:    pump_d = 3'b000;
        endcase
    end

    // State register with outputs registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= S_IDLE;
            cnt_q     <= '0;
            ab_q      <= 1'b0;
            pump_q    <= 3'b000;
            valve_q   <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rc_q      <= 8'd0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            ab_q      <= ab_d;
            pump_q    <= pump_d;
            valve_q   <= (st_d == S_DISPENSE);
            flush_q   <= (st_d == S_FLUSH);
            busy_q    <= (st_d != S_IDLE);
            done_q    <= fin;
            aborted_q <= fin && ab_q;
            if (fin && !ab_q) begin
                rc_q <= rc_q + 8'd1;
            end
        end
    end

    assign bus.pump_en   = pump_q;
    assign bus.valve_out = valve_q;
    assign bus.flush_en  = flush_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.run_count = rc_q;
    assign bus.state     = st_q;

endmodule

// File: tb/tb_demo2_pump_sequencer.sv
// Scoreboard bench for demo2_pump_sequencer.
// Expected per-cycle outputs are queued as stimulus is applied.
module tb_demo2_pump_sequencer;

    localparam int P3 = 3;
    localparam int P2 = 2;
    localparam int PM = 2;
    localparam int PD = 4;
    localparam int PF = 2;
    localparam int B2 = 1 + P3;
    localparam int B3 = B2 + P2;
    localparam int B4 = B3 + PM;
    localparam int B5 = B4 + PD;
    localparam int B6 = B5 + PF;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] pump;
        logic       valve;
        logic       flush;
        logic       busy;
        logic       done;
        logic       aborted;
        logic [7:0] rc;
    } exp_t;

    logic clk;
    logic rst_n;

    demo2_pump_sequencer_if bus ();
    demo2_pump_sequencer_if bz ();

    demo2_pump_sequencer #(
        .CNT_W(8), .T_PRIME3(P3), .T_PRIME2(P2),
        .T_MIX(PM), .T_DISP(PD), .T_FLUSH(PF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    demo2_pump_sequencer #(
        .CNT_W(8), .T_PRIME3(P3), .T_PRIME2(P2),
        .T_MIX(0), .T_DISP(PD), .T_FLUSH(PF)
    ) dut_z (
        .clk(clk), .rst_n(rst_n), .bus(bz.slave)
    );

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    int   rc_exp = 0;
    bit   pend_dn = 0;
    bit   pend_ab = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input bit dn,
                                input bit ab, input int rc);
        exp_t e;
        e.st      = st;
        e.pump    = (st == 3'd1) ? 3'b100 :
                    (st == 3'd2) ? 3'b110 :
                    (st == 3'd3 || st == 3'd4) ? 3'b111 : 3'b000;
        e.valve   = (st == 3'd4);
        e.flush   = (st == 3'd5);
        e.busy    = (st != 3'd0);
        e.done    = dn;
        e.aborted = ab;
        e.rc      = 8'(rc);
        return e;
    endfunction

    function automatic logic [2:0] st_at(input int i, input int ab);
        if (ab >= 1 && i > ab) return (i <= ab + PF) ? 3'd5 : 3'd0;
        if (i < 1)  return 3'd0;
        if (i < B2) return 3'd1;
        if (i < B3) return 3'd2;
        if (i < B4) return 3'd3;
        if (i < B5) return 3'd4;
        if (i < B6) return 3'd5;
        return 3'd0;
    endfunction

    // Scoreboard: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t o;
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            o = {bus.state, bus.pump_en, bus.valve_out, bus.flush_en,
                 bus.busy, bus.done, bus.aborted, bus.run_count};
            chk("sb", 32'(o), 32'(e));
        end
    end

    task automatic cyc(input bit s, input bit a, input exp_t e);
        @(posedge clk);
        #1;
        bus.start = s;
        bus.abort = a;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit s, input bit a);
        for (int i = 0; i < n; i++) begin
            cyc(i == 0 ? s : 1'b0, i == 0 ? a : 1'b0,
                mk(3'd0, pend_dn, pend_ab, rc_exp));
            pend_dn = 0;
            pend_ab = 0;
        end
    endtask

    task automatic run(input int ab_in, input bit restart, input int stop);
        int  ab_eff;
        int  len;
        bit  s;
        ab_eff = (ab_in >= 1 && ab_in < B5) ? ab_in : -1;
        len    = (ab_eff > 0) ? ab_eff + 1 + PF : B6;
        for (int i = 0; i < len; i++) begin
            if (stop >= 0 && i >= stop) return;
            s = (i == 0) || (restart && (i == 3 || i == 10));
            cyc(s, i == ab_in,
                mk(st_at(i, ab_eff), i == 0 && pend_dn,
                   i == 0 && pend_ab, rc_exp));
        end
        pend_dn = 1;
        pend_ab = (ab_eff > 0);
        if (ab_eff < 0) rc_exp = (rc_exp + 1) % 256;
    endtask

    initial begin
        logic [2:0] zexp [14];
        exp_t       o;
        int         guard;
        zexp = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4,
                 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0, 3'd0};
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bz.start  = 1'b0;
        bz.abort  = 1'b0;
        #12;
        o = {bus.state, bus.pump_en, bus.valve_out, bus.flush_en,
             bus.busy, bus.done, bus.aborted, bus.run_count};
        chk("reset_vals", 32'(o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-length MIX still takes one cycle.
        @(posedge clk);
        #1;
        bz.start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            bz.start = 1'b0;
            chk("zmix_state", 32'(bz.state), 32'(zexp[i]));
            if (i == 12) chk("zmix_done", 32'(bz.done), 32'd1);
        end

        idle(2, 1'b0, 1'b0);
        run(-1, 1'b0, -1);
        idle(2, 1'b0, 1'b0);
        run(6, 1'b0, -1);
        idle(2, 1'b0, 1'b0);
        run(-1, 1'b1, -1);
        idle(1, 1'b0, 1'b0);
        run(12, 1'b0, -1);
        idle(1, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b1);
        run(1, 1'b0, -1);
        run(11, 1'b0, -1);
        idle(1, 1'b0, 1'b0);

        for (int k = 0; k < 256; k++) run(-1, 1'b0, -1);
        idle(2, 1'b0, 1'b0);

        // Reset in DISPENSE must close everything before the next edge.
        run(-1, 1'b0, 9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        #2;
        chk("pre_rst_valve", 32'(bus.valve_out), 32'd1);
        rst_n = 1'b0;
        #1;
        o = {bus.state, bus.pump_en, bus.valve_out, bus.flush_en,
             bus.busy, bus.done, bus.aborted, bus.run_count};
        chk("async_rst", 32'(o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        rc_exp  = 0;
        pend_dn = 0;
        pend_ab = 0;
        run(-1, 1'b0, -1);
        idle(2, 1'b0, 1'b0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/demo2_pump_sequencer.md
DEMO2_PUMP_SEQUENCER -- requirements
Module: demo2_pump_sequencer

Interface
REQ-001 Parameter: CNT_W, 8, width of the phase down-counter.
REQ-002 Parameter: T_PRIME3, 40, cycles soln3 pumps alone. It has the longest serpentine path.
REQ-003 Parameter: T_PRIME2, 20, cycles soln3+soln2 pump before soln1 joins.
REQ-004 Parameter: T_MIX, 30, cycles all three pumps run before output opens.
REQ-005 Parameter: T_DISP, 50, cycles output valve open.
REQ-006 Parameter: T_FLUSH, 16, cycles flush valve open after dispense or abort.
REQ-007 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-008 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-009 Port: start  input  1  single-cycle request to run one dispense sequence.
REQ-010 Port: abort  input  1  level/pulse; terminate the current sequence.
REQ-011 Port: pump_en  output  3  bit0=soln1, bit1=soln2, bit2=soln3 pump enables.
REQ-012 Port: valve_out  output  1  opens out port.
REQ-013 Port: flush_en  output  1  opens flush path.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse when a sequence ends.
REQ-016 Port: aborted  output  1  qualifies done; high with done when the run was aborted.
REQ-017 Port: run_count  output  8  completed (non-aborted) runs; wraps 255->0.
REQ-018 Port: state  output  3  current state encoding, for debug.

Function
REQ-019 States SHALL be IDLE=0, PRIME3=1, PRIME2=2, MIX=3, DISPENSE=4, FLUSH=5; codes 6-7 return to IDLE next cycle.
REQ-020 All outputs SHALL be registered and decoded from the state being entered, so they change in the same edge as the state.
REQ-021 Output map: IDLE 000/0/0; PRIME3 100; PRIME2 110; MIX 111; DISPENSE 111 + valve_out=1; FLUSH 000 + flush_en=1.
REQ-022 In IDLE, start=1 SHALL enter PRIME3 on the next edge and load the counter with T_PRIME3.
REQ-023 Each phase SHALL last exactly max(T_x,1) cycles; a parameter of 0 is treated as 1.
REQ-024 The transition SHALL occur when the counter equals 1, loading the next phase duration; chain PRIME3->PRIME2->MIX->DISPENSE->FLUSH->IDLE.
REQ-025 On FLUSH->IDLE, done SHALL pulse for 1 cycle coincident with IDLE entry.
REQ-026 On a normal FLUSH->IDLE, run_count SHALL increment by 1 with modulo-256 wrap.
REQ-027 start while busy=1 SHALL be ignored; it is not queued.
REQ-028 abort=1 in PRIME3, PRIME2, MIX or DISPENSE SHALL enter FLUSH next edge, load T_FLUSH and set an internal abort flag.
REQ-029 abort in FLUSH SHALL be ignored; the flush completes.
REQ-030 A FLUSH reached via abort SHALL end with done=1 and aborted=1, and run_count SHALL NOT increment.
REQ-031 abort=1 in IDLE SHALL be ignored; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-032 Parameters exceeding 2^CNT_W-1 are a configuration error, flagged by a synthesis-time check.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, pump_en=000, valve_out=0, flush_en=0, busy=0, done=0, aborted=0, run_count=0, counter=0, abort flag=0.
REQ-034 Reset asserted mid-sequence SHALL close every pump and valve immediately, without waiting for a clock edge and without a flush.
REQ-035 Reset release SHALL be synchronized externally; the first start is honoured on the first edge after release.

Verification
REQ-036 Nominal run, with T=3/2/2/4/2 and start at cycle 0: PRIME3 cycles 1-3, PRIME2 4-5, MIX 6-7, DISPENSE 8-11, FLUSH 12-13; done=1 and busy=0 at 14; run_count 0->1.
REQ-037 Abort in MIX at cycle 6: FLUSH cycles 7-8 with pumps 000; done=1 and aborted=1 at cycle 9; run_count unchanged.
REQ-038 start re-pulsed at cycles 3 and 10 during a run: sequence timing is identical to REQ-036, and exactly one done occurs.
REQ-039 T_MIX=0: MIX lasts exactly 1 cycle.
REQ-040 256 back-to-back runs: run_count reads 255, then 0.
REQ-041 rst_n low at cycle 9 (in DISPENSE): all outputs 0 asynchronously, before the next clk edge; state=0 after release.
